// File: rtl/jtdd_subshare.sv
// Shared-RAM mailbox between main CPU and sub CPU: dual-port RAM, bus-request/halt FSM, doorbells.
// Define JTDD_SHARE_ARB_EN to let main writes land in any state through a 1-entry write buffer.
module jtdd_subshare #(
  parameter int AW   = 10,
  parameter int DW   = 8,
  parameter int NCH  = 2,
  parameter int TOUT = 1023
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           cen,
  input  logic [AW-1:0]  main_addr,
  input  logic [DW-1:0]  main_din,
  input  logic           main_cs,
  input  logic           main_we,
  output logic [DW-1:0]  main_dout,
  output logic           main_wbusy,
  input  logic [AW-1:0]  sub_addr,
  input  logic [DW-1:0]  sub_din,
  input  logic           sub_cs,
  input  logic           sub_we,
  output logic [DW-1:0]  sub_dout,
  input  logic           halt_req,
  output logic           sub_busrq_n,
  input  logic           sub_busak_n,
  output logic           halted,
  output logic           timeout,
  input  logic [NCH-1:0] nmi_set,
  input  logic [NCH-1:0] nmi_ack,
  output logic [NCH-1:0] nmi_pend,
  output logic           sub_nmi_n,
  input  logic [NCH-1:0] irq_set,
  input  logic [NCH-1:0] irq_ack,
  output logic [NCH-1:0] irq_pend,
  output logic           main_irq
);

  localparam int CW = 10;
  localparam logic [CW-1:0] TOUT_C = CW'(TOUT);

  typedef enum logic [1:0] {RUN, REQ, HELD, REL} state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] val);
    return (val == TOUT_C) ? val : val + 1'b1;
  endfunction

  // Bus handshake FSM: all outputs registered alongside the state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= RUN;
      sub_busrq_n <= 1'b1;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      tick_cnt    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (halt_req) begin
            state       <= REQ;
            sub_busrq_n <= 1'b0;
            tick_cnt    <= '0;
          end
        end
        REQ: begin
          if (cen) tick_cnt <= sat_inc(tick_cnt);
          if (tick_cnt == TOUT_C) timeout <= 1'b1;
          // Withdrawal of the request beats a late acknowledge
          if (!halt_req) begin
            state       <= REL;
            sub_busrq_n <= 1'b1;
          end else if (!sub_busak_n) begin
            state  <= HELD;
            halted <= 1'b1;
          end
        end
        HELD: begin
          if (!halt_req) begin
            state       <= REL;
            halted      <= 1'b0;
            sub_busrq_n <= 1'b1;
          end
        end
        REL: begin
          if (sub_busak_n) state <= RUN;
        end
        default: begin
          state       <= RUN;
          sub_busrq_n <= 1'b1;
          halted      <= 1'b0;
        end
      endcase
    end
  end

  logic          sub_wr;
  logic          main_wr;
  logic          mwr_en;
  logic [AW-1:0] mwr_addr;
  logic [DW-1:0] mwr_data;
  logic [DW-1:0] main_rd;
  logic [DW-1:0] mem [2**AW];

  assign sub_wr  = sub_cs & sub_we;
  assign main_wr = main_cs & main_we;

`ifdef JTDD_SHARE_ARB_EN
  logic          wbuf_busy;
  logic [AW-1:0] wbuf_addr;
  logic [DW-1:0] wbuf_data;
  logic          bypass;
  logic          capture;
  logic          commit;
  logic          cancel;

  assign bypass  = main_wr & halted;
  assign capture = main_wr & ~halted & ~wbuf_busy;
  // A bypass write owns the main RAM port, so a pending commit waits one more clk
  assign commit  = wbuf_busy & ~bypass & ~(sub_wr && (sub_addr == wbuf_addr));
  assign cancel  = wbuf_busy & bypass & (main_addr == wbuf_addr);

  assign mwr_en     = bypass | commit;
  assign mwr_addr   = bypass ? main_addr : wbuf_addr;
  assign mwr_data   = bypass ? main_din  : wbuf_data;
  assign main_rd    = (wbuf_busy && (main_addr == wbuf_addr)) ? wbuf_data : mem[main_addr];
  assign main_wbusy = wbuf_busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wbuf_busy <= 1'b0;
    else       wbuf_busy <= capture | (wbuf_busy & ~commit & ~cancel);
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      wbuf_addr <= main_addr;
      wbuf_data <= main_din;
    end
  end
`else
  assign mwr_en     = main_wr & halted;
  assign mwr_addr   = main_addr;
  assign mwr_data   = main_din;
  assign main_rd    = mem[main_addr];
  assign main_wbusy = 1'b0;
`endif

  // RAM: synchronous read-before-write; the sub port is written last so it wins collisions
  always_ff @(posedge clk) begin
    if (mwr_en) mem[mwr_addr] <= mwr_data;
    if (sub_wr) mem[sub_addr] <= sub_din;
    if (main_cs) main_dout <= main_rd;
    if (sub_cs)  sub_dout  <= mem[sub_addr];
  end

  logic [NCH-1:0] nmi_prev;

  // Doorbells: a new set beats an ack arriving in the same clk
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nmi_prev <= '0;
      nmi_pend <= '0;
      irq_pend <= '0;
    end else begin
      nmi_prev <= nmi_set;
      nmi_pend <= (nmi_pend & ~nmi_ack) | (nmi_set & ~nmi_prev);
      irq_pend <= (irq_pend & ~irq_ack) | irq_set;
    end
  end

  assign sub_nmi_n = ~|nmi_pend;
  assign main_irq  = |irq_pend;

endmodule

// File: tb/tb_jtdd_subshare.sv
// Bench for jtdd_subshare: directed handshake/RAM sequences, doorbell vector table, random model run.
module tb_jtdd_subshare;
  localparam int AW  = 10;
  localparam int DW  = 8;
  localparam int NCH = 2;

  logic           clk = 1'b0;
  logic           rstn, cen;
  logic [AW-1:0]  main_addr, sub_addr;
  logic [DW-1:0]  main_din, sub_din, main_dout, sub_dout;
  logic           main_cs, main_we, sub_cs, sub_we, main_wbusy;
  logic           halt_req, sub_busrq_n, sub_busak_n, halted, timeout;
  logic [NCH-1:0] nmi_set, nmi_ack, nmi_pend, irq_set, irq_ack, irq_pend;
  logic           sub_nmi_n, main_irq;

  always #5 clk = ~clk;

  jtdd_subshare #(.AW(AW), .DW(DW), .NCH(NCH), .TOUT(1023)) dut (
    .clk(clk), .rstn(rstn), .cen(cen),
    .main_addr(main_addr), .main_din(main_din), .main_cs(main_cs), .main_we(main_we),
    .main_dout(main_dout), .main_wbusy(main_wbusy),
    .sub_addr(sub_addr), .sub_din(sub_din), .sub_cs(sub_cs), .sub_we(sub_we), .sub_dout(sub_dout),
    .halt_req(halt_req), .sub_busrq_n(sub_busrq_n), .sub_busak_n(sub_busak_n),
    .halted(halted), .timeout(timeout),
    .nmi_set(nmi_set), .nmi_ack(nmi_ack), .nmi_pend(nmi_pend), .sub_nmi_n(sub_nmi_n),
    .irq_set(irq_set), .irq_ack(irq_ack), .irq_pend(irq_pend), .main_irq(main_irq)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NCH-1:0] nset, nack, iset, iack, exp_nmi, exp_irq;
  } db_vec_t;

  db_vec_t tbl[10];

  logic [DW-1:0]  mem_m [1024];
  bit             known [1024];
  logic [NCH-1:0] nmi_m, irq_m, prev_m;
  logic [AW-1:0]  sa, ma;
  logic [DW-1:0]  sd, exp_s, exp_m;
  logic           sw, chk_s, chk_m;

`ifdef JTDD_SHARE_ARB_EN
  localparam bit ARB = 1'b1;
`else
  localparam bit ARB = 1'b0;
`endif

  initial begin
    tbl[0] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[1] = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01};
    tbl[2] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
    tbl[3] = '{2'b11, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    tbl[4] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    tbl[5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10};
    tbl[6] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00};
    tbl[7] = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11};
    tbl[8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
    tbl[9] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};

    rstn = 1'b0; cen = 1'b1;
    main_addr = '0; main_din = '0; main_cs = 1'b0; main_we = 1'b0;
    sub_addr = '0; sub_din = '0; sub_cs = 1'b0; sub_we = 1'b0;
    halt_req = 1'b0; sub_busak_n = 1'b1;
    nmi_set = '0; nmi_ack = '0; irq_set = '0; irq_ack = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busrq_n", 32'(sub_busrq_n), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_nmi_pend", 32'(nmi_pend), 32'd0);
    chk("rst_irq_pend", 32'(irq_pend), 32'd0);
    chk("rst_wbusy", 32'(main_wbusy), 32'd0);
    chk("rst_sub_nmi_n", 32'(sub_nmi_n), 32'd1);
    chk("rst_main_irq", 32'(main_irq), 32'd0);
    rstn = 1'b1;
    step();

    sub_cs = 1'b1; sub_we = 1'b1; sub_addr = 10'h000; sub_din = 8'h11;
    step();
    sub_addr = 10'h010; sub_din = 8'h3C;
    step();
    sub_we = 1'b0; sub_cs = 1'b0;

    halt_req = 1'b1;
    step();
    chk("t1_busrq_req", 32'(sub_busrq_n), 32'd0);
    chk("t1_halted_req", 32'(halted), 32'd0);
    step();
    chk("t1_halted_wait", 32'(halted), 32'd0);
    sub_busak_n = 1'b0;
    step();
    chk("t1_halted_held", 32'(halted), 32'd1);
    chk("t1_busrq_held", 32'(sub_busrq_n), 32'd0);

    main_cs = 1'b1; main_we = 1'b1; main_addr = 10'h3FF; main_din = 8'h5A;
    step();
    main_we = 1'b0;
    step();
    chk("t3_main_rd", 32'(main_dout), 32'h5A);
    main_cs = 1'b0;

    halt_req = 1'b0;
    step();
    chk("t1_halted_rel", 32'(halted), 32'd0);
    chk("t1_busrq_rel", 32'(sub_busrq_n), 32'd1);
    sub_busak_n = 1'b1;
    step();
    chk("t1_busrq_run", 32'(sub_busrq_n), 32'd1);

    sub_cs = 1'b1; sub_addr = 10'h000;
    step();
    chk("t3_sub_rd0", 32'(sub_dout), 32'h11);
    sub_addr = 10'h3FF;
    #1;
    chk("t3_sub_latency", 32'(sub_dout), 32'h11);
    step();
    chk("t3_sub_rd3ff", 32'(sub_dout), 32'h5A);

    main_cs = 1'b1; main_we = 1'b1; main_addr = 10'h010; main_din = 8'hA5;
    sub_addr = 10'h010;
    step();
    main_cs = 1'b0; main_we = 1'b0;
    chk("t4_wbusy_1", 32'(main_wbusy), ARB ? 32'd1 : 32'd0);
    chk("t4_sub_old", 32'(sub_dout), 32'h3C);
    step();
    chk("t4_wbusy_2", 32'(main_wbusy), 32'd0);
    step();
    chk("t4_sub_rd", 32'(sub_dout), ARB ? 32'hA5 : 32'h3C);
    sub_cs = 1'b0;

    halt_req = 1'b1; cen = 1'b1;
    step();
    chk("t2_busrq", 32'(sub_busrq_n), 32'd0);
    repeat (1018) step();
    chk("t2_no_timeout_yet", 32'(timeout), 32'd0);
    repeat (11) step();
    chk("t2_timeout", 32'(timeout), 32'd1);
    chk("t2_still_req", 32'(sub_busrq_n), 32'd0);
    chk("t2_not_halted", 32'(halted), 32'd0);
    halt_req = 1'b0;
    step();
    step();
    chk("t2_timeout_sticky", 32'(timeout), 32'd1);
    chk("t2_busrq_run", 32'(sub_busrq_n), 32'd1);

    halt_req = 1'b1;
    step();
    chk("t6_busrq_req", 32'(sub_busrq_n), 32'd0);
    irq_set = 2'b01; nmi_set = 2'b01;
    step();
    irq_set = 2'b00; nmi_set = 2'b00;
    chk("t6_irq_pend", 32'(irq_pend), 32'b01);
    chk("t6_main_irq", 32'(main_irq), 32'd1);
    chk("t6_nmi_pend", 32'(nmi_pend), 32'b01);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_rst_busrq", 32'(sub_busrq_n), 32'd1);
    chk("t6_rst_timeout", 32'(timeout), 32'd0);
    chk("t6_rst_irq", 32'(irq_pend), 32'd0);
    chk("t6_rst_nmi", 32'(nmi_pend), 32'd0);
    chk("t6_rst_main_irq", 32'(main_irq), 32'd0);
    chk("t6_rst_sub_nmi_n", 32'(sub_nmi_n), 32'd1);
    halt_req = 1'b0;
    step();
    rstn = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      nmi_set = tbl[i].nset; nmi_ack = tbl[i].nack;
      irq_set = tbl[i].iset; irq_ack = tbl[i].iack;
      step();
      chk($sformatf("tbl%0d_nmi_pend", i), 32'(nmi_pend), 32'(tbl[i].exp_nmi));
      chk($sformatf("tbl%0d_irq_pend", i), 32'(irq_pend), 32'(tbl[i].exp_irq));
      chk($sformatf("tbl%0d_sub_nmi_n", i), 32'(sub_nmi_n), 32'(~|tbl[i].exp_nmi));
      chk($sformatf("tbl%0d_main_irq", i), 32'(main_irq), 32'(|tbl[i].exp_irq));
    end
    nmi_set = '0; nmi_ack = '0; irq_set = '0; irq_ack = '0;

    sub_cs = 1'b1; sub_we = 1'b1;
    for (int a = 0; a < 16; a++) begin
      sub_addr = AW'(10'h100 + a);
      sub_din  = DW'($urandom);
      mem_m[10'h100 + a] = sub_din;
      known[10'h100 + a] = 1'b1;
      step();
    end
    nmi_m  = tbl[9].exp_nmi;
    irq_m  = tbl[9].exp_irq;
    prev_m = '0;

    main_cs = 1'b1;
    for (int c = 0; c < 300; c++) begin
      sa = AW'(10'h100 + $urandom_range(0, 15));
      ma = AW'(10'h100 + $urandom_range(0, 15));
      sw = 1'($urandom);
      sd = DW'($urandom);
      sub_addr = sa; sub_we = sw; sub_din = sd;
      main_addr = ma; main_din = DW'($urandom);
      main_we = ARB ? 1'b0 : 1'($urandom);
      cen = 1'($urandom);
      nmi_set = NCH'($urandom); nmi_ack = NCH'($urandom);
      irq_set = NCH'($urandom); irq_ack = NCH'($urandom);

      chk_s = known[sa]; exp_s = mem_m[sa];
      chk_m = known[ma]; exp_m = mem_m[ma];
      for (int i = 0; i < NCH; i++) begin
        if (nmi_set[i] && !prev_m[i]) nmi_m[i] = 1'b1;
        else if (nmi_ack[i])          nmi_m[i] = 1'b0;
        if (irq_set[i])               irq_m[i] = 1'b1;
        else if (irq_ack[i])          irq_m[i] = 1'b0;
      end
      prev_m = nmi_set;
      if (sw) begin
        mem_m[sa] = sd;
        known[sa] = 1'b1;
      end

      step();
      chk("rnd_nmi_pend", 32'(nmi_pend), 32'(nmi_m));
      chk("rnd_irq_pend", 32'(irq_pend), 32'(irq_m));
      chk("rnd_sub_nmi_n", 32'(sub_nmi_n), 32'(~|nmi_m));
      chk("rnd_main_irq", 32'(main_irq), 32'(|irq_m));
      if (chk_s) chk("rnd_sub_dout", 32'(sub_dout), 32'(exp_s));
      if (chk_m) chk("rnd_main_dout", 32'(main_dout), 32'(exp_m));
      chk("rnd_halted", 32'(halted), 32'd0);
    end
    main_cs = 1'b0; main_we = 1'b0; sub_cs = 1'b0; sub_we = 1'b0;
    nmi_set = '0; nmi_ack = '0; irq_set = '0; irq_ack = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
